// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses the instruction ROM and
// registers the fetched word into the IF/ID pipeline register.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'hBFC00000,
    parameter logic [31:0] ROM_BASE = 32'hBFC00000,
    parameter logic [31:0] ROM_LAST = 32'hBFC00FFC,
    parameter logic [31:0] NOP      = 32'h00000013
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_data_i,
    output logic [31:0] id_instr_o,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_pc_plus4_o,
    output logic        id_valid_o,
    output logic        fetch_fault_o
);

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t      state_r, state_nxt_s;
    logic [31:0] pc_r, pc_nxt_s;
    logic [31:0] instr_nxt_s, idpc_nxt_s, idpc4_nxt_s;
    logic        valid_nxt_s, fault_nxt_s;
    logic [31:0] pc_plus4_s;

    function automatic logic pc_illegal(input logic [31:0] pc);
        return (pc < ROM_BASE) || (pc > ROM_LAST) || (pc[1:0] != 2'b00);
    endfunction

    assign pc_plus4_s  = pc_r + 32'd4;
    assign imem_addr_o = pc_r;

    // Next-state and next IF/ID contents; redirect beats stall, stall beats fetch.
    always_comb begin
        state_nxt_s = state_r;
        pc_nxt_s    = pc_r;
        instr_nxt_s = id_instr_o;
        idpc_nxt_s  = id_pc_o;
        idpc4_nxt_s = id_pc_plus4_o;
        valid_nxt_s = id_valid_o;
        fault_nxt_s = fetch_fault_o;
        if (redirect_i) begin
            state_nxt_s = RUN;
            pc_nxt_s    = redirect_pc_i;
            instr_nxt_s = NOP;
            idpc_nxt_s  = 32'h0;
            idpc4_nxt_s = 32'h0;
            valid_nxt_s = 1'b0;
            fault_nxt_s = 1'b0;
        end else if (stall_i) begin
            state_nxt_s = state_r;
        end else begin
            case (state_r)
                RUN: begin
                    if (pc_illegal(pc_r)) begin
                        state_nxt_s = HALT;
                        instr_nxt_s = NOP;
                        idpc_nxt_s  = 32'h0;
                        idpc4_nxt_s = 32'h0;
                        valid_nxt_s = 1'b0;
                        fault_nxt_s = 1'b1;
                    end else begin
                        pc_nxt_s    = pc_plus4_s;
                        instr_nxt_s = imem_data_i;
                        idpc_nxt_s  = pc_r;
                        idpc4_nxt_s = pc_plus4_s;
                        valid_nxt_s = 1'b1;
                        fault_nxt_s = 1'b0;
                    end
                end
                HALT: begin
                    instr_nxt_s = NOP;
                    idpc_nxt_s  = 32'h0;
                    idpc4_nxt_s = 32'h0;
                    valid_nxt_s = 1'b0;
                    fault_nxt_s = 1'b1;
                end
                default: begin
                    state_nxt_s = HALT;
                    instr_nxt_s = NOP;
                    idpc_nxt_s  = 32'h0;
                    idpc4_nxt_s = 32'h0;
                    valid_nxt_s = 1'b0;
                    fault_nxt_s = 1'b1;
                end
            endcase
        end
    end

    // State, PC and IF/ID register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_r       <= RUN;
            pc_r          <= RESET_PC;
            id_instr_o    <= NOP;
            id_pc_o       <= 32'h0;
            id_pc_plus4_o <= 32'h0;
            id_valid_o    <= 1'b0;
            fetch_fault_o <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            pc_r          <= pc_nxt_s;
            id_instr_o    <= instr_nxt_s;
            id_pc_o       <= idpc_nxt_s;
            id_pc_plus4_o <= idpc4_nxt_s;
            id_valid_o    <= valid_nxt_s;
            fetch_fault_o <= fault_nxt_s;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: stimulus queues expected IF/ID state per
// edge, a monitor pops and compares just after each rising edge.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        stall_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = 32'h0;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_data_i;
    logic [31:0] id_instr_o, id_pc_o, id_pc_plus4_o;
    logic        id_valid_o, fetch_fault_o;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        valid;
        logic        fault;
        logic [31:0] addr;
        logic        chk_pc;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    localparam logic [31:0] NOP = 32'h00000013;

    fetch_stage dut (
        .clk_i(clk), .rst_ni(rst_ni), .stall_i(stall_i),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .imem_addr_o(imem_addr_o), .imem_data_i(imem_data_i),
        .id_instr_o(id_instr_o), .id_pc_o(id_pc_o),
        .id_pc_plus4_o(id_pc_plus4_o), .id_valid_o(id_valid_o),
        .fetch_fault_o(fetch_fault_o)
    );

    always #5 clk = ~clk;

    // ROM model: each word encodes its own low address bits
    assign imem_data_i = {16'hC0DE, imem_addr_o[15:0]};

    task automatic step(input string name, input logic rst, input logic stall,
                        input logic redir, input logic [31:0] rpc,
                        input logic [31:0] e_instr, input logic [31:0] e_pc,
                        input logic [31:0] e_pc4, input logic e_valid,
                        input logic e_fault, input logic [31:0] e_addr,
                        input logic e_chk_pc);
        exp_t e;
        @(negedge clk);
        rst_ni = rst;
        stall_i = stall;
        redirect_i = redir;
        redirect_pc_i = rpc;
        e.name = name; e.instr = e_instr; e.pc = e_pc; e.pc4 = e_pc4;
        e.valid = e_valid; e.fault = e_fault; e.addr = e_addr; e.chk_pc = e_chk_pc;
        exp_q.push_back(e);
    endtask

    task automatic fetch(input string name, input logic [31:0] pc);
        step(name, 1'b1, 1'b0, 1'b0, 32'h0, {16'hC0DE, pc[15:0]}, pc,
             pc + 32'd4, 1'b1, 1'b0, pc + 32'd4, 1'b1);
    endtask

    task automatic bubble(input string name, input logic stall, input logic redir,
                          input logic [31:0] rpc, input logic fault, input logic [31:0] addr);
        step(name, 1'b1, stall, redir, rpc, NOP, 32'h0, 32'h0, 1'b0, fault, addr, 1'b0);
    endtask

    // Monitor: compare DUT state one time unit after every rising edge.
    initial begin
        exp_t e;
        logic bad;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                bad = (id_instr_o !== e.instr) || (id_valid_o !== e.valid) ||
                      (fetch_fault_o !== e.fault) || (imem_addr_o !== e.addr) ||
                      (e.chk_pc && ((id_pc_o !== e.pc) || (id_pc_plus4_o !== e.pc4)));
                tests++;
                if (bad) begin
                    fails++;
                    $display("FAIL %s: got instr=%h pc=%h pc4=%h v=%b f=%b addr=%h, want instr=%h pc=%h pc4=%h v=%b f=%b addr=%h",
                             e.name, id_instr_o, id_pc_o, id_pc_plus4_o, id_valid_o,
                             fetch_fault_o, imem_addr_o, e.instr, e.pc, e.pc4,
                             e.valid, e.fault, e.addr);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        step("reset0", 1'b0, 1'b0, 1'b0, 32'h0, NOP, 32'h0, 32'h0, 1'b0, 1'b0, 32'hBFC00000, 1'b1);
        step("reset1", 1'b0, 1'b0, 1'b0, 32'h0, NOP, 32'h0, 32'h0, 1'b0, 1'b0, 32'hBFC00000, 1'b1);
        fetch("run_w0", 32'hBFC00000);
        fetch("run_w1", 32'hBFC00004);
        fetch("run_w2", 32'hBFC00008);
        for (int i = 0; i < 3; i++)
            step("stall_hold", 1'b1, 1'b1, 1'b0, 32'h0, 32'hC0DE0008, 32'hBFC00008,
                 32'hBFC0000C, 1'b1, 1'b0, 32'hBFC0000C, 1'b1);
        fetch("stall_resume", 32'hBFC0000C);
        bubble("redir_stall_bubble", 1'b1, 1'b1, 32'hBFC00100, 1'b0, 32'hBFC00100);
        fetch("redir_target", 32'hBFC00100);
        bubble("redir_end", 1'b0, 1'b1, 32'hBFC00FF8, 1'b0, 32'hBFC00FF8);
        fetch("end_ff8", 32'hBFC00FF8);
        fetch("end_ffc", 32'hBFC00FFC);
        bubble("past_end_fault", 1'b0, 1'b0, 32'h0, 1'b1, 32'hBFC01000);
        for (int i = 0; i < 10; i++)
            bubble("halt_hold", 1'b0, 1'b0, 32'h0, 1'b1, 32'hBFC01000);
        bubble("halt_stall", 1'b1, 1'b0, 32'h0, 1'b1, 32'hBFC01000);
        bubble("halt_redirect", 1'b0, 1'b1, 32'hBFC00000, 1'b0, 32'hBFC00000);
        fetch("halt_resume", 32'hBFC00000);
        bubble("misalign_redir", 1'b0, 1'b1, 32'hBFC00002, 1'b0, 32'hBFC00002);
        bubble("misalign_fault", 1'b0, 1'b0, 32'h0, 1'b1, 32'hBFC00002);
        bubble("misalign_halt", 1'b0, 1'b0, 32'h0, 1'b1, 32'hBFC00002);
        step("reset_mid_halt", 1'b0, 1'b1, 1'b1, 32'h12345678, NOP, 32'h0, 32'h0,
             1'b0, 1'b0, 32'hBFC00000, 1'b1);
        fetch("post_reset_w0", 32'hBFC00000);
        fetch("post_reset_w1", 32'hBFC00004);
        bubble("redir_low", 1'b0, 1'b1, 32'h00000000, 1'b0, 32'h00000000);
        bubble("low_fault", 1'b0, 1'b0, 32'h0, 1'b1, 32'h00000000);
        bubble("redir_top", 1'b0, 1'b1, 32'hFFFFFFFC, 1'b0, 32'hFFFFFFFC);
        bubble("top_fault", 1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFFFFFC);
        bubble("final_redir", 1'b0, 1'b1, 32'hBFC00010, 1'b0, 32'hBFC00010);
        fetch("final_fetch", 32'hBFC00010);
        @(negedge clk);
        @(negedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
